mc_maindec: RTL and testbench

MC_MAINDEC -- requirements
Module: mc_maindec

---
 rtl/mc_maindec_if.sv | 30 +++
 rtl/mc_maindec.sv | 144 ++++++++++++++
 tb/tb_mc_maindec.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mc_maindec_if.sv
// rtl/mc_maindec_if.sv - opcode/flag inputs and control outputs of the multicycle main decoder
interface mc_maindec_if;
   logic [5:0] op;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       alusrca;
   logic       regdst;
   logic       memtoreg;
   logic       zeroext;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] aluop;
   logic [3:0] state;

   modport master (
      output op, zero,
      input  pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst,
             memtoreg, zeroext, alusrcb, pcsrc, aluop, state
   );

   modport slave (
      input  op, zero,
      output pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst,
             memtoreg, zeroext, alusrcb, pcsrc, aluop, state
   );
endinterface

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle MIPS main decoder Moore FSM; MC_MAINDEC_BNE_EN adds bne
module mc_maindec (
   input  logic        clk,
   input  logic        reset_n,
   mc_maindec_if.slave bus
);
   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] RTYPEEX = 4'd6;
   localparam logic [3:0] RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] IWB     = 4'd10;
   localparam logic [3:0] ORIEX   = 4'd11;
   localparam logic [3:0] JEX     = 4'd12;
`ifdef MC_MAINDEC_BNE_EN
   localparam logic [3:0] BNEEX   = 4'd13;
`endif

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       pcwrite;
   logic       branch;
   logic       bne;
   logic       memwrite_s;
   logic       irwrite_s;
   logic       regwrite_s;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;
   end

   // Terminal states and unused encodings all fall through the default to FETCH.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (bus.op)
               6'b100011, 6'b101011: state_d = MEMADR;
               6'b000000:            state_d = RTYPEEX;
               6'b000100:            state_d = BEQEX;
               6'b001000:            state_d = ADDIEX;
               6'b001101:            state_d = ORIEX;
               6'b000010:            state_d = JEX;
`ifdef MC_MAINDEC_BNE_EN
               6'b000101:            state_d = BNEEX;
`endif
               default:              state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (bus.op == 6'b101011) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = IWB;
         ORIEX:   state_d = IWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      pcwrite      = 1'b0;
      branch       = 1'b0;
      bne          = 1'b0;
      memwrite_s   = 1'b0;
      irwrite_s    = 1'b0;
      regwrite_s   = 1'b0;
      bus.iord     = 1'b0;
      bus.alusrca  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.zeroext  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      bus.aluop    = 3'b000;
      case (state_q)
         FETCH: begin
            irwrite_s   = 1'b1;
            pcwrite     = 1'b1;
            bus.alusrcb = 2'b01;
         end
         DECODE: bus.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         MEMRD: bus.iord = 1'b1;
         MEMWB: begin
            bus.memtoreg = 1'b1;
            regwrite_s   = 1'b1;
         end
         MEMWR: begin
            bus.iord   = 1'b1;
            memwrite_s = 1'b1;
         end
         RTYPEEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 3'b010;
         end
         RTYPEWB: begin
            bus.regdst = 1'b1;
            regwrite_s = 1'b1;
         end
         BEQEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 3'b001;
            bus.pcsrc   = 2'b01;
            branch      = 1'b1;
         end
         ORIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.aluop   = 3'b011;
            bus.zeroext = 1'b1;
         end
         IWB: regwrite_s = 1'b1;
         JEX: begin
            bus.pcsrc = 2'b10;
            pcwrite   = 1'b1;
         end
`ifdef MC_MAINDEC_BNE_EN
         BNEEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 3'b001;
            bus.pcsrc   = 2'b01;
            bne         = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Write enables are masked while reset is held so an abandoned instruction commits nothing.
   assign bus.pcen     = reset_n & (pcwrite | (branch & bus.zero) | (bne & ~bus.zero));
   assign bus.memwrite = reset_n & memwrite_s;
   assign bus.irwrite  = reset_n & irwrite_s;
   assign bus.regwrite = reset_n & regwrite_s;
   assign bus.state    = state_q;
endmodule

// File: tb/tb_mc_maindec.sv
// tb/tb_mc_maindec.sv - self-checking bench for mc_maindec against an instruction-path model
module tb_mc_maindec;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   bit   run = 1'b0;

   mc_maindec_if bif ();

   mc_maindec dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Control word: {pcen,memwrite,irwrite,regwrite,iord,alusrca,regdst,memtoreg,zeroext,alusrcb,pcsrc,aluop}
   function automatic logic [15:0] model_outs(input int s, input logic z, input logic rn);
      logic pcw, br, bn, mw, irw, rw, iord, asa, rd, m2r, zx;
      logic [1:0] asb, psrc;
      logic [2:0] aop;
      {pcw, br, bn, mw, irw, rw, iord, asa, rd, m2r, zx} = '0;
      asb = 2'b00; psrc = 2'b00; aop = 3'b000;
      if (s == 0)                begin irw = 1; pcw = 1; asb = 2'b01; end
      if (s == 1)                asb = 2'b11;
      if (s == 2 || s == 9)      begin asa = 1; asb = 2'b10; end
      if (s == 3)                iord = 1;
      if (s == 4)                begin m2r = 1; rw = 1; end
      if (s == 5)                begin iord = 1; mw = 1; end
      if (s == 6)                begin asa = 1; aop = 3'b010; end
      if (s == 7)                begin rd = 1; rw = 1; end
      if (s == 8)                begin asa = 1; aop = 3'b001; psrc = 2'b01; br = 1; end
      if (s == 11)               begin asa = 1; asb = 2'b10; aop = 3'b011; zx = 1; end
      if (s == 10)               rw = 1;
      if (s == 12)               begin psrc = 2'b10; pcw = 1; end
`ifdef MC_MAINDEC_BNE_EN
      if (s == 13)               begin asa = 1; aop = 3'b001; psrc = 2'b01; bn = 1; end
`endif
      return {rn & (pcw | (br & z) | (bn & ~z)), rn & mw, rn & irw, rn & rw,
              iord, asa, rd, m2r, zx, asb, psrc, aop};
   endfunction

   int m_state = 0;
   int m_path[$];

   always @(negedge clk) begin
      if (run) begin
         chk("state", {28'd0, bif.state}, m_state);
         chk($sformatf("outs@%0d", m_state),
             {16'd0, bif.pcen, bif.memwrite, bif.irwrite, bif.regwrite, bif.iord, bif.alusrca,
              bif.regdst, bif.memtoreg, bif.zeroext, bif.alusrcb, bif.pcsrc, bif.aluop},
             {16'd0, model_outs(m_state, bif.zero, reset_n)});
      end
      // The model walks the instruction's state path, chosen once at DECODE.
      if (!reset_n) begin
         m_state = 0;
         m_path.delete();
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         case (bif.op)
            6'b100011: m_path = '{2, 3, 4};
            6'b101011: m_path = '{2, 5};
            6'b000000: m_path = '{6, 7};
            6'b000100: m_path = '{8};
            6'b001000: m_path = '{9, 10};
            6'b001101: m_path = '{11, 10};
            6'b000010: m_path = '{12};
`ifdef MC_MAINDEC_BNE_EN
            6'b000101: m_path = '{13};
`endif
            default:   m_path.delete();
         endcase
         m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
      end else begin
         m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
      end
   end

   task automatic run_instr(input logic [5:0] o, input logic z, input int exp_len,
                            input logic [31:0] exp_seq, input string nm,
                            output logic br_pcen, output logic [2:0] dec_wr);
      logic [31:0] seq;
      int n;
      bif.op = o;
      bif.zero = z;
      seq = 0;
      n = 0;
      br_pcen = 1'bx;
      dec_wr = 3'bxxx;
      do begin
         seq = {seq[27:0], bif.state};
         n++;
         if (bif.state == 4'd8 || bif.state == 4'd13) br_pcen = bif.pcen;
         if (bif.state == 4'd1) dec_wr = {bif.memwrite, bif.regwrite, bif.pcen};
         @(posedge clk);
         #1;
      end while (bif.state != 4'd0 && n < 10);
      chk({nm, "_len"}, n, exp_len);
      chk({nm, "_seq"}, seq, exp_seq);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      logic       br;
      logic [2:0] dw;
      int         n;
      reset_n = 1'b0;
      bif.op = 6'b000000;
      bif.zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {28'd0, bif.state}, 32'd0);
      chk("rst_irwrite", {31'd0, bif.irwrite}, 32'd0);
      chk("rst_pcen", {31'd0, bif.pcen}, 32'd0);
      chk("rst_alusrcb", {30'd0, bif.alusrcb}, 32'd1);
      run = 1'b1;
      reset_n = 1'b1;
      #1;
      chk("fetch_pcen", {31'd0, bif.pcen}, 32'd1);

      run_instr(6'b100011, 1'b0, 5, 32'h01234, "lw", br, dw);
      run_instr(6'b101011, 1'b0, 4, 32'h0125, "sw", br, dw);
      run_instr(6'b000000, 1'b1, 4, 32'h0167, "rtype", br, dw);
      run_instr(6'b000100, 1'b1, 3, 32'h018, "beq_t", br, dw);
      chk("beq_t_pcen", {31'd0, br}, 32'd1);
      run_instr(6'b000100, 1'b0, 3, 32'h018, "beq_n", br, dw);
      chk("beq_n_pcen", {31'd0, br}, 32'd0);
      run_instr(6'b001000, 1'b0, 4, 32'h019A, "addi", br, dw);
      run_instr(6'b001101, 1'b1, 4, 32'h01BA, "ori", br, dw);
      run_instr(6'b000010, 1'b0, 3, 32'h01C, "j", br, dw);
      run_instr(6'b111111, 1'b1, 2, 32'h01, "illegal", br, dw);
      chk("illegal_dec_wr", {29'd0, dw}, 32'd0);
`ifdef MC_MAINDEC_BNE_EN
      run_instr(6'b000101, 1'b0, 3, 32'h01D, "bne_t", br, dw);
      chk("bne_t_pcen", {31'd0, br}, 32'd1);
      run_instr(6'b000101, 1'b1, 3, 32'h01D, "bne_n", br, dw);
      chk("bne_n_pcen", {31'd0, br}, 32'd0);
`else
      run_instr(6'b000101, 1'b0, 2, 32'h01, "bne_off", br, dw);
`endif

      bif.op = 6'b101011;
      bif.zero = 1'b0;
      n = 0;
      while (bif.state != 4'd5 && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("memwr_reached", {28'd0, bif.state}, 32'd5);
      chk("memwr_we", {31'd0, bif.memwrite}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("memwr_rst_we", {31'd0, bif.memwrite}, 32'd0);
      @(posedge clk);
      #1;
      chk("memwr_rst_state", {28'd0, bif.state}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_irwrite", {31'd0, bif.irwrite}, 32'd1);
      run_instr(6'b000000, 1'b0, 4, 32'h0167, "rtype2", br, dw);

      @(negedge clk);
      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
